// File: rtl/seg_mux_driver.sv
// Scans NUM_DIGITS latched segment patterns onto shared active-low cathodes/anodes; optional SEG_DIM_EN adds brightness_i PWM.
// Latency: registered outputs; position k is presented after edge k, and the frame's shadow is loaded at frame start.
// Backpressure: none; free-running scan, and enable_i only blanks the outputs while the timing keeps running.
module seg_mux_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_DIGITS*8-1:0] segments_i,
    input  logic                    enable_i,
`ifdef SEG_DIM_EN
    input  logic [3:0]              brightness_i,
`endif
    output logic [NUM_DIGITS-1:0]   anodes_no,
    output logic [7:0]              cathodes_no,
    output logic                    frame_o
);

    // Counter is at least 4 bits wide so the dimming compare always has counter[3:0].
    localparam int CW = ($clog2(CLK_DIV) < 4) ? 4 : $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [NUM_DIGITS*8-1:0] shadow, shadow_nxt;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic [7:0]              digit_seg;
    logic                    frame_start;
    logic                    cnt_wrap;
    logic                    in_drive;
    logic                    duty_on;

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign in_drive = 1'b1;
        end else begin : g_blank
            assign in_drive = (cnt >= CW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEG_DIM_EN
    assign duty_on = (cnt[3:0] < brightness_i);
`else
    assign duty_on = 1'b1;
`endif

    always_comb begin
        frame_start = (cnt == '0) && (idx == '0);
        cnt_wrap    = (cnt == CW'(CLK_DIV - 1));
        cnt_nxt     = cnt_wrap ? '0 : cnt + 1'b1;
        idx_nxt     = idx;
        if (cnt_wrap) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
        // Digit 0 of a new frame must already show the pattern being latched this cycle.
        shadow_nxt = frame_start ? segments_i : shadow;
        digit_seg  = shadow_nxt[idx*8 +: 8];
        anode_sel  = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            anodes_no   <= '1;
            cathodes_no <= 8'hFF;
            frame_o     <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shadow  <= shadow_nxt;
            frame_o <= frame_start;
            if (enable_i && in_drive) begin
                cathodes_no <= ~digit_seg;
                anodes_no   <= duty_on ? anode_sel : '1;
            end else begin
                cathodes_no <= 8'hFF;
                anodes_no   <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Randomized and directed bench for seg_mux_driver against an arithmetic position/frame model.
module tb_seg_mux_driver;

    localparam int ND    = 4;
    localparam int CDIV  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = ND * CDIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] segments = '0;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SEG_DIM_EN
    logic [3:0] bright_main = 4'hF;
    logic [3:0] bright_dim  = 4'h0;
    logic [3:0] dim_an;
    logic [7:0] dim_ca;
    logic       dim_fr;

    seg_mux_driver #(.NUM_DIGITS(ND), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK)) dut (
        .clk_i(clk), .rst_ni(rst_n), .segments_i(segments), .enable_i(enable),
        .brightness_i(bright_main),
        .anodes_no(anodes), .cathodes_no(cathodes), .frame_o(frame));

    seg_mux_driver #(.NUM_DIGITS(ND), .CLK_DIV(40), .BLANK_CYCLES(0)) dut_dim (
        .clk_i(clk), .rst_ni(rst_n), .segments_i(segments), .enable_i(enable),
        .brightness_i(bright_dim),
        .anodes_no(dim_an), .cathodes_no(dim_ca), .frame_o(dim_fr));
`else
    seg_mux_driver #(.NUM_DIGITS(ND), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK)) dut (
        .clk_i(clk), .rst_ni(rst_n), .segments_i(segments), .enable_i(enable),
        .anodes_no(anodes), .cathodes_no(cathodes), .frame_o(frame));
`endif

    // Model: position since frame start picks slot and offset; the frame's pattern is captured at position 0.
    int          pos = 0;
    logic [31:0] latched = '0;
    logic [3:0]  exp_an;
    logic [7:0]  exp_ca;
    logic        exp_fr;

    task automatic tick();
        int p, slot, off;
        if (!rst_n) begin
            pos    = 0;
            exp_an = 4'hF;
            exp_ca = 8'hFF;
            exp_fr = 1'b0;
        end else begin
            p    = pos % FRAME;
            slot = p / CDIV;
            off  = p % CDIV;
            if (p == 0) latched = segments;
            exp_fr = (p == 0);
            if (enable && off >= BLANK) begin
                exp_an = ~(4'b0001 << slot);
                exp_ca = ~latched[8*slot +: 8];
            end else begin
                exp_an = 4'hF;
                exp_ca = 8'hFF;
            end
            pos++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({anodes, cathodes, frame} !== {4'hF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc%0d: got an=%h ca=%h fr=%b want an=F ca=FF fr=0", i, anodes, cathodes, frame);
            end
        end
    endtask

    task automatic test_normal_scan();
        segments = 32'h074F5B66;
        enable   = 1'b1;
        hold_reset(2);
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({anodes, cathodes, frame} !== {exp_an, exp_ca, exp_fr}) begin
                errors++;
                $display("FAIL scan k=%0d: got an=%h ca=%h fr=%b want an=%h ca=%h fr=%b",
                         k, anodes, cathodes, frame, exp_an, exp_ca, exp_fr);
            end
            if (k == 0 || k == 2 || k == 12 || k == 32 || k == 35) begin
                logic [12:0] want;
                case (k)
                    0:       want = {4'hF, 8'hFF, 1'b1};
                    2:       want = {4'b1110, 8'h99, 1'b0};
                    12:      want = {4'b1101, 8'hA4, 1'b0};
                    default: want = {4'b0111, 8'hF8, 1'b0};
                endcase
                checks++;
                if ({anodes, cathodes, frame} !== want) begin
                    errors++;
                    $display("FAIL scan_fixed k=%0d: got %h want %h", k, {anodes, cathodes, frame}, want);
                end
            end
        end
    endtask

    task automatic test_tearing();
        segments = 32'h074F5B66;
        hold_reset(1);
        for (int k = 0; k < 50; k++) begin
            if (k == 15) segments = 32'hFFFFFFFF;
            tick();
            checks++;
            if ({anodes, cathodes, frame} !== {exp_an, exp_ca, exp_fr}) begin
                errors++;
                $display("FAIL tearing k=%0d: got an=%h ca=%h fr=%b want an=%h ca=%h fr=%b",
                         k, anodes, cathodes, frame, exp_an, exp_ca, exp_fr);
            end
            if (k == 22 || k == 42) begin
                logic [7:0] want_ca;
                want_ca = (k == 22) ? 8'hB0 : 8'h00;
                checks++;
                if (cathodes !== want_ca) begin
                    errors++;
                    $display("FAIL tearing_fixed k=%0d: got ca=%h want %h", k, cathodes, want_ca);
                end
            end
        end
    endtask

    task automatic test_enable();
        segments = 32'h3F06_5B4F;
        hold_reset(1);
        for (int k = 0; k < 90; k++) begin
            enable = !(k >= 20 && k <= 29);
            tick();
            checks++;
            if ({anodes, cathodes, frame} !== {exp_an, exp_ca, exp_fr}) begin
                errors++;
                $display("FAIL enable k=%0d: got an=%h ca=%h fr=%b want an=%h ca=%h fr=%b",
                         k, anodes, cathodes, frame, exp_an, exp_ca, exp_fr);
            end
            if (k == 25 || k == 40 || k == 80) begin
                logic [12:0] want;
                want = (k == 25) ? {4'hF, 8'hFF, 1'b0} : {4'hF, 8'hFF, 1'b1};
                checks++;
                if ({anodes, cathodes, frame} !== want) begin
                    errors++;
                    $display("FAIL enable_fixed k=%0d: got %h want %h", k, {anodes, cathodes, frame}, want);
                end
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        segments = 32'h1122_3344;
        hold_reset(1);
        for (int k = 0; k < 25; k++) tick();
        segments = 32'hAABB_CC5A;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({anodes, cathodes, frame} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_dark: got an=%h ca=%h fr=%b want an=F ca=FF fr=0", anodes, cathodes, frame);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ((k == 0 && frame !== 1'b1) || (k >= 2 && {anodes, cathodes} !== {4'b1110, 8'hA5})) begin
                errors++;
                $display("FAIL reset_mid_restart k=%0d: got an=%h ca=%h fr=%b", k, anodes, cathodes, frame);
            end
        end
    endtask

    task automatic test_random();
        hold_reset(1);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9) == 0) segments = $urandom;
            if ($urandom_range(9) == 0) enable = ~enable;
            rst_n = ($urandom_range(59) != 0);
            tick();
            checks++;
            if ({anodes, cathodes, frame} !== {exp_an, exp_ca, exp_fr} || $countones(~anodes) > 1) begin
                errors++;
                $display("FAIL random k=%0d: got an=%h ca=%h fr=%b want an=%h ca=%h fr=%b",
                         k, anodes, cathodes, frame, exp_an, exp_ca, exp_fr);
            end
        end
        rst_n  = 1'b1;
        enable = 1'b1;
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        segments = $urandom;
        for (int b = 0; b < 3; b++) begin
            bright_dim = (b == 0) ? 4'd0 : (b == 1) ? 4'd8 : 4'($urandom_range(15));
            hold_reset(1);
            for (int k = 0; k < 160; k++) begin
                int slot, off;
                logic [3:0] want;
                slot = k / 40;
                off  = k % 40;
                want = ((off % 16) < int'(bright_dim)) ? ~(4'b0001 << slot) : 4'hF;
                tick();
                checks++;
                if (dim_an !== want || dim_fr !== (k == 0)) begin
                    errors++;
                    $display("FAIL dim b=%0d k=%0d: got an=%h fr=%b want an=%h", bright_dim, k, dim_an, dim_fr, want);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_scan();
        test_tearing();
        test_enable();
        test_reset_mid();
        test_random();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
